// File: rtl/dmem_arb_pkg.sv
// Shared types and the priority decode for the data-memory port arbiter.
// Grant order: locked DMA burst, starved DMA, CPU, then idle DMA.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  typedef struct packed {
    owner_t own;
    logic   starve;
  } arb_pick_t;

  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned BURST_W = 4;

  function automatic arb_pick_t arb_pick(
    input logic cpu_req,
    input logic dma_req,
    input logic lock_ok,
    input logic starve_hit
  );
    arb_pick_t p;
    p.own    = OWN_NONE;
    p.starve = 1'b0;
    priority case (1'b1)
      (dma_req && lock_ok): p.own = OWN_DMA;
      (dma_req && starve_hit): begin
        p.own    = OWN_DMA;
        p.starve = 1'b1;
      end
      cpu_req: p.own = OWN_CPU;
      dma_req: p.own = OWN_DMA;
      default: p.own = OWN_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dmem_arb_age_ctr.sv
// DMA wait-age and burst-length counters feeding the arbiter's
// starvation and burst-lock decisions.
module dmem_arb_age_ctr
  import dmem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic dma_req_i,
  input  logic dma_own_i,
  input  logic dma_grant_i,
  input  logic grant_starve_i,
  input  logic cpu_grant_i,
  input  logic cpu_ack_i,
  input  logic dma_ack_i,
  input  logic dma_lock_i,
  output logic starve_hit_o,
  output logic lock_ok_o
);

  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               locked_q, locked_d;

  always_comb begin
    wait_d = wait_q;
    if (dma_grant_i) begin
      wait_d = '0;
    end else if (dma_req_i && !dma_own_i && (wait_q != '1)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Starvation grants do not count toward the burst.
  always_comb begin
    burst_d = burst_q;
    if (cpu_grant_i) begin
      burst_d = '0;
    end else if (dma_ack_i && !dma_lock_i) begin
      burst_d = '0;
    end else if (dma_grant_i && dma_lock_i && !grant_starve_i
                 && (burst_q != '1)) begin
      burst_d = burst_q + 1'b1;
    end
  end

  always_comb begin
    locked_d = locked_q;
    if (dma_ack_i) begin
      locked_d = dma_lock_i;
    end else if (cpu_ack_i) begin
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q   <= '0;
      burst_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      wait_q   <= wait_d;
      burst_q  <= burst_d;
      locked_q <= locked_d;
    end
  end

  assign starve_hit_o = (wait_q >= WAIT_W'(STARVE_LIMIT));
  assign lock_ok_o    = locked_q && (burst_q < BURST_W'(MAX_BURST));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter between CPU load/store and DMA.
// Each access runs IDLE -> ISSUE -> RESP with a one-cycle ack in RESP.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic              busy
);

  arb_state_t        state_q;
  owner_t            own_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              cpu_ack_q;
  logic              dma_ack_q;

  arb_pick_t         pick;
  logic              starve_hit;
  logic              lock_ok;
  logic              grant;
  logic              cpu_grant;
  logic              dma_grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_comb begin
    pick = arb_pick(cpu_req, dma_req, lock_ok, starve_hit);
  end

  assign grant     = (state_q == IDLE) && (pick.own != OWN_NONE);
  assign cpu_grant = grant && (pick.own == OWN_CPU);
  assign dma_grant = grant && (pick.own == OWN_DMA);

  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (pick.own == OWN_DMA) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  dmem_arb_age_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .MAX_BURST    (MAX_BURST)
  ) u_age (
    .clk            (clk),
    .reset          (reset),
    .dma_req_i      (dma_req),
    .dma_own_i      (own_q == OWN_DMA),
    .dma_grant_i    (dma_grant),
    .grant_starve_i (pick.starve),
    .cpu_grant_i    (cpu_grant),
    .cpu_ack_i      (cpu_ack_q),
    .dma_ack_i      (dma_ack_q),
    .dma_lock_i     (dma_lock),
    .starve_hit_o   (starve_hit),
    .lock_ok_o      (lock_ok)
  );

  // The command latch is only loaded on a grant, so it holds through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      own_q     <= OWN_NONE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_en_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q  <= ISSUE;
            own_q    <= pick.own;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            mem_en_q <= 1'b1;
            mem_we_q <= sel_we;
          end
        end
        ISSUE: begin
          state_q   <= RESP;
          mem_en_q  <= 1'b0;
          mem_we_q  <= 1'b0;
          cpu_ack_q <= (own_q == OWN_CPU);
          dma_ack_q <= (own_q == OWN_DMA);
        end
        RESP: begin
          state_q   <= IDLE;
          own_q     <= OWN_NONE;
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          own_q     <= OWN_NONE;
          mem_en_q  <= 1'b0;
          mem_we_q  <= 1'b0;
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = own_q;
  assign busy      = (state_q != IDLE);
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_stall = cpu_req && !cpu_ack_q;
  assign cpu_rdata = (cpu_ack_q && !we_q) ? mem_rdata : '0;
  assign dma_rdata = (dma_ack_q && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural
// synchronous-read memory attached to the mem_* port.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [4:0]  cpu_addr, dma_addr;
  logic [31:0] cpu_wdata, dma_wdata;
  logic        cpu_ack, cpu_stall, dma_ack;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_en, mem_we, busy;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  owner;

  logic [31:0] mem [0:31];
  int          wlog[$];
  logic        bk_we = 1'b0;
  logic [4:0]  bk_addr = '0;
  logic [31:0] bk_data = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_lock  (dma_lock),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .owner     (owner),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (bk_we) begin
      mem[bk_addr] <= bk_data;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wlog.push_back(int'(mem_addr));
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    bk_addr = a;
    bk_data = d;
    bk_we   = 1'b1;
    step();
    bk_we   = 1'b0;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    dma_lock = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mem: en=%b we=%b want 0 0", mem_en, mem_we);
    end
    n_checks++;
    if (owner !== 2'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_owner: owner=%0d busy=%b want 0 0", owner, busy);
    end
    n_checks++;
    if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ack: cpu=%b dma=%b want 0 0", cpu_ack, dma_ack);
    end
    n_checks++;
    if (cpu_rdata !== 32'd0 || dma_rdata !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_rdata: cpu=%h dma=%h want 0", cpu_rdata, dma_rdata);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_cpu_load();
    do_reset();
    poke(5'h03, 32'hDEADBEEF);
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03;
    @(negedge clk);
    n_checks++;
    if (cpu_stall !== 1'b1 || mem_en !== 1'b0 || owner !== 2'd0) begin
      n_errors++;
      $display("FAIL load_c0: stall=%b en=%b owner=%0d want 1 0 0",
               cpu_stall, mem_en, owner);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'h03
        || owner !== 2'd1 || cpu_stall !== 1'b1) begin
      n_errors++;
      $display("FAIL load_c1: en=%b we=%b addr=%h owner=%0d stall=%b want 1 0 03 1 1",
               mem_en, mem_we, mem_addr, owner, cpu_stall);
    end
    step();
    @(negedge clk);
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || cpu_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL load_c2: ack=%b rdata=%h stall=%b want 1 deadbeef 0",
               cpu_ack, cpu_rdata, cpu_stall);
    end
    step();
    cpu_req = 0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || owner !== 2'd0 || cpu_ack !== 1'b0) begin
      n_errors++;
      $display("FAIL load_c3: busy=%b owner=%0d ack=%b want 0 0 0",
               busy, owner, cpu_ack);
    end
    step();
  endtask

  task automatic test_simultaneous();
    int  cpu_at, dma_at;
    logic cdrop, ddrop;
    do_reset();
    poke(5'd1, 32'd0);
    poke(5'd2, 32'd0);
    wlog.delete();
    cpu_at = -1; dma_at = -1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'd1; cpu_wdata = 32'h11;
    dma_req = 1; dma_we = 1; dma_addr = 5'd2; dma_wdata = 32'h22;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      cdrop = cpu_ack;
      ddrop = dma_ack;
      if (cpu_ack && cpu_at < 0) cpu_at = c;
      if (dma_ack && dma_at < 0) dma_at = c;
      step();
      if (cdrop) cpu_req = 0;
      if (ddrop) dma_req = 0;
    end
    n_checks++;
    if (cpu_at != 2) begin
      n_errors++;
      $display("FAIL simul_cpu_ack: cycle %0d want 2", cpu_at);
    end
    n_checks++;
    if (dma_at != 5) begin
      n_errors++;
      $display("FAIL simul_dma_ack: cycle %0d want 5", dma_at);
    end
    n_checks++;
    if (wlog.size() != 2 || wlog[0] != 1 || wlog[1] != 2) begin
      n_errors++;
      $display("FAIL simul_order: %0d writes, first=%0d want 2 writes 1 then 2",
               wlog.size(), (wlog.size() > 0) ? wlog[0] : -1);
    end
    n_checks++;
    if (mem[1] !== 32'h11 || mem[2] !== 32'h22) begin
      n_errors++;
      $display("FAIL simul_data: m1=%h m2=%h want 11 22", mem[1], mem[2]);
    end
  endtask

  task automatic test_starvation();
    int          dma_at, ncpu;
    logic [31:0] drd;
    do_reset();
    poke(5'd4, 32'hA5A50004);
    dma_at = -1; ncpu = 0; drd = '0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd0;
    dma_req = 1; dma_we = 0; dma_addr = 5'd4; dma_lock = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (cpu_ack && dma_at < 0) ncpu++;
      if (dma_ack && dma_at < 0) begin
        dma_at = c;
        drd = dma_rdata;
      end
      step();
      if (dma_at >= 0) begin
        dma_req = 0;
        cpu_req = 0;
        break;
      end
    end
    step(); step(); step();
    n_checks++;
    if (dma_at < 0 || dma_at > 11) begin
      n_errors++;
      $display("FAIL starve_latency: dma ack cycle %0d want 0..11", dma_at);
    end
    n_checks++;
    if (ncpu != 3) begin
      n_errors++;
      $display("FAIL starve_cpu_grants: %0d cpu acks before dma want 3", ncpu);
    end
    n_checks++;
    if (drd !== 32'hA5A50004) begin
      n_errors++;
      $display("FAIL starve_rdata: %h want a5a50004", drd);
    end
    n_checks++;
    if (dut.u_age.wait_q !== 8'd0) begin
      n_errors++;
      $display("FAIL starve_wait_clear: wait_cnt=%0d want 0", dut.u_age.wait_q);
    end
  endtask

  task automatic test_burst();
    int         ndma, cpu_at;
    logic       dseen, cseen;
    logic [3:0] burst_at;
    do_reset();
    poke(5'd8, 32'hFFFF_FFFF);
    poke(5'd11, 32'hFFFF_FFFF);
    ndma = 0; cpu_at = -1; burst_at = 4'hF;
    dma_req = 1; dma_we = 1; dma_lock = 1;
    dma_addr = 5'd8; dma_wdata = 32'd0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      dseen = dma_ack;
      cseen = cpu_ack;
      if (dma_ack) ndma++;
      if (cpu_ack) begin
        cpu_at = c;
        burst_at = dut.u_age.burst_q;
      end
      step();
      if (c == 0) begin
        cpu_req = 1; cpu_we = 0; cpu_addr = 5'd0;
      end
      if (dseen) begin
        dma_addr = 5'(8 + ndma);
        dma_wdata = 32'(ndma);
      end
      if (cseen) begin
        cpu_req = 0;
        dma_req = 0;
        break;
      end
    end
    step(); step(); step();
    n_checks++;
    if (ndma != 4) begin
      n_errors++;
      $display("FAIL burst_count: %0d dma acks before cpu want 4", ndma);
    end
    n_checks++;
    if (cpu_at != 14) begin
      n_errors++;
      $display("FAIL burst_cpu_ack: cycle %0d want 14", cpu_at);
    end
    n_checks++;
    if (burst_at !== 4'd0) begin
      n_errors++;
      $display("FAIL burst_clear: burst_cnt=%0d want 0", burst_at);
    end
    n_checks++;
    if (mem[8] !== 32'd0 || mem[11] !== 32'd3) begin
      n_errors++;
      $display("FAIL burst_data: m8=%h m11=%h want 0 3", mem[8], mem[11]);
    end
  endtask

  task automatic test_reset_in_issue();
    int ack_at;
    do_reset();
    poke(5'd7, 32'd0);
    ack_at = -1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'd7; cpu_wdata = 32'h77;
    @(negedge clk);
    step();
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_issue_pre: en=%b we=%b want 1 1", mem_en, mem_we);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || owner !== 2'd0) begin
      n_errors++;
      $display("FAIL rst_issue_drop: en=%b we=%b owner=%0d want 0 0 0",
               mem_en, mem_we, owner);
    end
    step();
    n_checks++;
    if (cpu_ack !== 1'b0 || mem[7] !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_issue_abort: ack=%b m7=%h want 0 0", cpu_ack, mem[7]);
    end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cpu_ack && ack_at < 0) ack_at = c;
      step();
      if (ack_at >= 0) begin
        cpu_req = 0;
        break;
      end
    end
    step();
    n_checks++;
    if (ack_at != 2 || mem[7] !== 32'h77) begin
      n_errors++;
      $display("FAIL rst_issue_retry: ack cycle %0d m7=%h want 2 77",
               ack_at, mem[7]);
    end
  endtask

  task automatic test_lone_dma();
    logic [1:0] exp_own [0:3];
    exp_own[0] = 2'd0; exp_own[1] = 2'd2;
    exp_own[2] = 2'd2; exp_own[3] = 2'd0;
    do_reset();
    poke(5'd6, 32'h6666);
    dma_req = 1; dma_we = 0; dma_addr = 5'd6; dma_lock = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (owner !== exp_own[c]) begin
        n_errors++;
        $display("FAIL lone_owner_c%0d: owner=%0d want %0d", c, owner, exp_own[c]);
      end
      if (c == 2) begin
        n_checks++;
        if (dma_ack !== 1'b1 || dma_rdata !== 32'h6666 || cpu_ack !== 1'b0) begin
          n_errors++;
          $display("FAIL lone_ack: ack=%b rdata=%h cpu_ack=%b want 1 6666 0",
                   dma_ack, dma_rdata, cpu_ack);
        end
      end
      if (c == 1 || c == 3) begin
        n_checks++;
        if (dut.u_age.wait_q !== 8'd0) begin
          n_errors++;
          $display("FAIL lone_wait_c%0d: wait_cnt=%0d want 0", c, dut.u_age.wait_q);
        end
      end
      step();
      if (c == 2) dma_req = 0;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_cpu_load();
    test_simultaneous();
    test_starvation();
    test_burst();
    test_reset_in_issue();
    test_lone_dma();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Arbitrates the single-port data memory between the CPU load/store path and a DMA/peripheral requester (timer capture, future UART buffer). Sequences each access as ISSUE then RESP, returns a one-cycle ack with read data, and drives the CPU stall. CPU has fixed priority, bounded by a DMA starvation limit and a DMA burst lock.

Parameters:
ADDR_W, 5, data memory word-address width.
DATA_W, 32, data word width.
STARVE_LIMIT, 8, DMA wait cycles after which DMA wins the next arbitration (1..255).
MAX_BURST, 4, maximum consecutive locked DMA grants before CPU is reconsidered (1..15).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
cpu_req  in  1  CPU access request; held with command until cpu_ack
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  store data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  load data, valid only while cpu_ack=1
cpu_stall  out  1  cpu_req & ~cpu_ack
dma_req  in  1  DMA access request; held until dma_ack
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W  word address
dma_wdata  in  DATA_W  write data
dma_lock  in  1  request burst ownership for the next beat
dma_ack  out  1  one-cycle completion pulse
dma_rdata  out  DATA_W  read data, valid only while dma_ack=1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  synchronous read data, valid the cycle after mem_en
owner  out  2  0=none, 1=CPU, 2=DMA
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; all outputs 0; wait_cnt=0; burst_cnt=0; latched command cleared. An in-flight access is aborted: mem_en/mem_we drop immediately, no ack is issued, and the requester must re-request.
- FSM states: IDLE, ISSUE, RESP.
- IDLE: arbitrate if any request is present; latch winner's we/addr/wdata; -> ISSUE. Otherwise stay.
- Priority, first match wins: (1) dma_req & lock_active; (2) dma_req & wait_cnt>=STARVE_LIMIT; (3) cpu_req; (4) dma_req.
- lock_active = previous completed grant was DMA, with dma_lock=1 at its ack, and burst_cnt<MAX_BURST.
- ISSUE: mem_en=1; mem_we/addr/wdata driven from the latch. -> RESP.
- RESP: mem_en=0. Owner's ack=1 and rdata=mem_rdata (zero for writes). -> IDLE.
- Latency: request seen in IDLE at cycle 0 -> ack in cycle 2. Throughput is one access per 3 cycles. No back-to-back from RESP, because the completing requester's req is still high in RESP.
- owner is valid in ISSUE and RESP; it is 0 in IDLE.
- wait_cnt: increments every cycle dma_req=1 and DMA is not owner; saturates at 255; clears on DMA grant.
- burst_cnt: +1 on each DMA grant made by rule (1) or (4) while dma_lock=1; clears on any CPU grant or when dma_lock=0 at DMA ack.
- Simultaneous cpu_req and dma_req with no lock and no starvation: CPU wins. DMA is granted on the next IDLE if cpu_req has dropped, or via starvation.
- A request dropped before grant is ignored. A request dropped after grant is an illegal protocol; the access still completes.
- The latched command is stable from ISSUE through RESP regardless of requester inputs.
- cpu_stall is combinational and glitch-free because cpu_ack is decoded from the state flops.

Decomposition:
- dmem_arb_pkg: arb_state_t enum {IDLE, ISSUE, RESP}; owner_t enum {OWN_NONE=0, OWN_CPU=1, OWN_DMA=2}; function for the priority decode.
- Sub-module dmem_arb_age_ctr holds the saturating wait_cnt and burst_cnt with their clear/increment rules and outputs starve_hit/lock_ok. The top level holds the FSM and the command latch.

Test Plan:
- CPU load addr 5'h03 (mem holds 32'hDEADBEEF): cpu_req at cycle 0 -> mem_en=1, addr=3 at cycle 1; cpu_ack=1, cpu_rdata=32'hDEADBEEF at cycle 2; cpu_stall=1 in cycles 0–1 and 0 in cycle 2.
- Simultaneous CPU store (addr 1, data 32'h11) and DMA store (addr 2, data 32'h22): CPU ack at cycle 2, DMA ack at cycle 5; mem words 1 and 2 written in that order.
- CPU requests continuously while DMA waits: DMA is granted once wait_cnt reaches 8, and its ack arrives within 8+3 cycles of the first dma_req.
- DMA burst with dma_lock=1 and cpu_req held high: exactly 4 consecutive DMA acks (MAX_BURST), then CPU is granted, then burst_cnt=0.
- Reset asserted in ISSUE of a CPU store: mem_en/mem_we drop in the same cycle; no cpu_ack; owner=0; after release, the re-issued request completes normally.
- Lone DMA read with dma_lock=0: dma_ack at cycle 2; wait_cnt remains 0; owner sequence is 0, 2, 2, 0.
